// File: rtl/voting_pkg.sv
// -----------------------------------------------------------------------------
// voting_pkg
// Shared definitions for the voting session controller:
//   - state_t         : ballot session states (LOCKED / ARMED / HOLD)
//   - default constants for candidate count, tally width and the two timers
//   - onehot_count    : number of set bits in a (zero-extended) vote vector
//   - is_single_hot   : true when exactly one vote bit is set
// -----------------------------------------------------------------------------
package voting_pkg;

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        ARMED  = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int DEF_N_CAND      = 4;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_HOLD_CYCLES = 100;
    localparam int DEF_ARM_TIMEOUT = 1000;

    // Widest vote vector the helper functions accept; callers zero-extend.
    localparam int MAX_CAND = 32;

    function automatic logic [5:0] onehot_count(input logic [MAX_CAND-1:0] bits);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < MAX_CAND; i++) begin
            n = n + {5'd0, bits[i]};
        end
        return n;
    endfunction

    function automatic logic is_single_hot(input logic [MAX_CAND-1:0] bits);
        return (onehot_count(bits) == 6'd1);
    endfunction

endpackage

// File: rtl/vote_tally.sv
// -----------------------------------------------------------------------------
// vote_tally
// Bank of N_CAND saturating tally counters plus a saturating total counter,
// with a registered read port.
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous, active-high; clears all counters and outputs
//   inc          in   increment strobe (one accepted vote this cycle)
//   inc_sel      in   candidate index to increment when inc=1
//   read_en      in   1 = present tally[result_sel] on result_count
//   result_sel   in   candidate index to read
//   result_count out  registered tally of result_sel (0 when disabled/out of range)
//   total_count  out  registered total of accepted votes
// -----------------------------------------------------------------------------
module vote_tally #(
    parameter int N_CAND = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic [SEL_W-1:0] inc_sel,
    input  logic             read_en,
    input  logic [SEL_W-1:0] result_sel,
    output logic [CNT_W-1:0] result_count,
    output logic [CNT_W-1:0] total_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] tally [N_CAND];
    logic [CNT_W-1:0] read_value;

    // Mux by comparison rather than direct indexing so that result_sel values
    // beyond the last candidate read as 0 without an out-of-range access.
    always_comb begin
        read_value = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (SEL_W'(i) == result_sel) begin
                read_value = tally[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_CAND; i++) begin
                tally[i] <= '0;
            end
            total_count  <= '0;
            result_count <= '0;
        end else begin
            if (inc) begin
                for (int i = 0; i < N_CAND; i++) begin
                    if ((SEL_W'(i) == inc_sel) && (tally[i] != CNT_MAX)) begin
                        tally[i] <= tally[i] + CNT_W'(1);
                    end
                end
                if (total_count != CNT_MAX) begin
                    total_count <= total_count + CNT_W'(1);
                end
            end
            // Reads the pre-increment value: one-cycle latency from result_sel.
            result_count <= read_en ? read_value : '0;
        end
    end

endmodule

// File: rtl/vote_session_controller.sv
// -----------------------------------------------------------------------------
// vote_session_controller
// Sequences one ballot per officer arming and tallies votes for N_CAND
// candidates. A ballot is armed from LOCKED, accepts exactly one single-hot
// vote (multi-press ballots are spoiled), expires after ARM_TIMEOUT cycles,
// and is followed by a HOLD lockout of HOLD_CYCLES cycles.
//
// Ports:
//   clock         in   system clock
//   reset         in   synchronous, active-high; aborts any ballot
//   valid_vote    in   one-cycle vote pulses, bit i = candidate i
//   enable_voter  in   officer pulse arming one ballot (ignored when mode=1)
//   mode          in   0 = voting, 1 = result display
//   result_sel    in   candidate shown on result_count
//   ready         out  high while a ballot is armed
//   vote_ack      out  one-cycle pulse, vote counted
//   spoiled       out  one-cycle pulse, multi-press ballot rejected
//   timeout       out  one-cycle pulse, armed ballot expired
//   cand_led      out  one-hot accepted candidate, held through HOLD
//   result_count  out  tally of result_sel when mode=1, else 0
//   total_count   out  total accepted votes
// -----------------------------------------------------------------------------
module vote_session_controller
    import voting_pkg::*;
#(
    parameter int N_CAND      = DEF_N_CAND,
    parameter int SEL_W       = 2,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int ARM_TIMEOUT = DEF_ARM_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_CAND-1:0] valid_vote,
    input  logic              enable_voter,
    input  logic              mode,
    input  logic [SEL_W-1:0]  result_sel,
    output logic              ready,
    output logic              vote_ack,
    output logic              spoiled,
    output logic              timeout,
    output logic [N_CAND-1:0] cand_led,
    output logic [CNT_W-1:0]  result_count,
    output logic [CNT_W-1:0]  total_count
);

    // Counter widths sized to hold the limit value, never narrower than 1 bit.
    localparam int ARM_W  = $clog2(ARM_TIMEOUT + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_t              state, state_next;
    logic [ARM_W-1:0]    arm_cnt, arm_cnt_next;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_next;
    logic                ready_next, ack_next, spoil_next, tout_next;
    logic [N_CAND-1:0]   led_next;
    logic                inc;
    logic [SEL_W-1:0]    inc_sel;
    logic [MAX_CAND-1:0] vote_bits;
    logic                single_vote;

    function automatic logic [SEL_W-1:0] hot_index(input logic [N_CAND-1:0] bits);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (bits[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

    assign vote_bits   = MAX_CAND'(valid_vote);
    assign single_vote = is_single_hot(vote_bits);

    always_comb begin
        state_next    = state;
        arm_cnt_next  = arm_cnt;
        hold_cnt_next = hold_cnt;
        ack_next      = 1'b0;
        spoil_next    = 1'b0;
        tout_next     = 1'b0;
        led_next      = cand_led;
        inc           = 1'b0;
        inc_sel       = hot_index(valid_vote);

        case (state)
            LOCKED: begin
                led_next = '0;
                if (enable_voter && !mode) begin
                    state_next   = ARMED;
                    arm_cnt_next = '0;
                end
            end
            ARMED: begin
                // Priority: mode switch, then a vote, then expiry, so a vote
                // landing on the expiry cycle is still counted.
                if (mode) begin
                    state_next = LOCKED;
                end else if (single_vote) begin
                    inc           = 1'b1;
                    ack_next      = 1'b1;
                    led_next      = valid_vote;
                    state_next    = HOLD;
                    hold_cnt_next = '0;
                end else if (valid_vote != '0) begin
                    spoil_next    = 1'b1;
                    led_next      = '0;
                    state_next    = HOLD;
                    hold_cnt_next = '0;
                end else if (arm_cnt == ARM_LAST) begin
                    tout_next  = 1'b1;
                    state_next = LOCKED;
                end else begin
                    arm_cnt_next = arm_cnt + ARM_W'(1);
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = LOCKED;
                    led_next   = '0;
                end else begin
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_next = LOCKED;
                led_next   = '0;
            end
        endcase

        ready_next = (state_next == ARMED);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= LOCKED;
            arm_cnt  <= '0;
            hold_cnt <= '0;
            ready    <= 1'b0;
            vote_ack <= 1'b0;
            spoiled  <= 1'b0;
            timeout  <= 1'b0;
            cand_led <= '0;
        end else begin
            state    <= state_next;
            arm_cnt  <= arm_cnt_next;
            hold_cnt <= hold_cnt_next;
            ready    <= ready_next;
            vote_ack <= ack_next;
            spoiled  <= spoil_next;
            timeout  <= tout_next;
            cand_led <= led_next;
        end
    end

    vote_tally #(
        .N_CAND (N_CAND),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W)
    ) u_tally (
        .clock        (clock),
        .reset        (reset),
        .inc          (inc),
        .inc_sel      (inc_sel),
        .read_en      (mode),
        .result_sel   (result_sel),
        .result_count (result_count),
        .total_count  (total_count)
    );

endmodule

// File: tb/tb_vote_session_controller.sv
// -----------------------------------------------------------------------------
// tb_vote_session_controller
// Drives directed ballot scenarios followed by random traffic. A timestamp-
// based reference model predicts tallies, ready/cand_led levels and the pulse
// sequence; pulses are queued and a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_vote_session_controller;

    localparam int N_CAND = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;
    localparam int HOLD   = 4;
    localparam int TOUT   = 8;
    localparam int CMAX   = 255;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N_CAND-1:0] valid_vote = '0;
    logic              enable_voter = 1'b0;
    logic              mode = 1'b0;
    logic [SEL_W-1:0]  result_sel = '0;
    logic              ready, vote_ack, spoiled, timeout;
    logic [N_CAND-1:0] cand_led;
    logic [CNT_W-1:0]  result_count, total_count;

    vote_session_controller #(
        .N_CAND      (N_CAND),
        .SEL_W       (SEL_W),
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD),
        .ARM_TIMEOUT (TOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .valid_vote   (valid_vote),
        .enable_voter (enable_voter),
        .mode         (mode),
        .result_sel   (result_sel),
        .ready        (ready),
        .vote_ack     (vote_ack),
        .spoiled      (spoiled),
        .timeout      (timeout),
        .cand_led     (cand_led),
        .result_count (result_count),
        .total_count  (total_count)
    );

    always #5 clock = ~clock;

    // kind: 1 = vote_ack, 2 = spoiled, 3 = timeout
    typedef struct {
        int          kind;
        logic [3:0]  led;
        int          total;
    } pulse_t;

    pulse_t exp_q[$];
    int checks = 0;
    int fails  = 0;

    // Reference model: ballot windows tracked by the edge number they began on.
    int         tally_m [N_CAND];
    int         total_m;
    bit         armed_m;
    int         arm_start;
    bit         hold_m;
    int         hold_start;
    logic [3:0] hold_led;
    int         edge_n = 0;

    // Expected levels after the most recent edge.
    bit          checking = 1'b0;
    logic [31:0] exp_result, exp_total;
    logic        exp_ready;
    logic [3:0]  exp_led;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit m,
                        input logic [3:0] v, input logic [1:0] sel);
        int     pop, idx, nr;
        pulse_t p;
        reset        = rst;
        enable_voter = en;
        mode         = m;
        valid_vote   = v;
        result_sel   = sel;
        edge_n++;
        pop = $countones(v);
        nr  = 0;
        if (rst) begin
            for (int i = 0; i < N_CAND; i++) tally_m[i] = 0;
            total_m = 0;
            armed_m = 0;
            hold_m  = 0;
        end else begin
            nr = m ? tally_m[sel] : 0;
            if (hold_m) begin
                // The HOLD window covers HOLD edges after the ballot closed.
                if (edge_n == hold_start + HOLD) hold_m = 0;
            end else if (armed_m) begin
                if (m) begin
                    armed_m = 0;
                end else if (pop == 1) begin
                    idx = 0;
                    for (int i = 0; i < N_CAND; i++) if (v[i]) idx = i;
                    if (tally_m[idx] < CMAX) tally_m[idx]++;
                    if (total_m < CMAX) total_m++;
                    p = '{1, v, total_m};
                    exp_q.push_back(p);
                    armed_m = 0; hold_m = 1; hold_start = edge_n; hold_led = v;
                end else if (pop >= 2) begin
                    p = '{2, 4'b0000, total_m};
                    exp_q.push_back(p);
                    armed_m = 0; hold_m = 1; hold_start = edge_n; hold_led = 4'b0000;
                end else if (edge_n == arm_start + TOUT) begin
                    p = '{3, 4'b0000, total_m};
                    exp_q.push_back(p);
                    armed_m = 0;
                end
            end else if (en && !m) begin
                armed_m   = 1;
                arm_start = edge_n;
            end
        end
        @(posedge clock);
        #1;
        exp_result = 32'(nr);
        exp_total  = 32'(total_m);
        exp_ready  = armed_m;
        exp_led    = hold_m ? hold_led : 4'b0000;
        checking   = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'b0000, 2'd0);
    endtask

    task automatic readback(input logic [1:0] sel);
        step(0, 0, 1, 4'b0000, sel);
    endtask

    // Monitor: level checks every cycle, pulse checks against the queue.
    pulse_t mon_p;
    int     npulse, kind;
    always @(negedge clock) begin
        if (checking) begin
            check("ready", 32'(ready), 32'(exp_ready));
            check("cand_led", 32'(cand_led), 32'(exp_led));
            check("total_count", 32'(total_count), exp_total);
            check("result_count", 32'(result_count), exp_result);
            npulse = int'(vote_ack) + int'(spoiled) + int'(timeout);
            if (npulse > 0) begin
                check("pulse_exclusive", 32'(npulse), 32'd1);
                kind = vote_ack ? 1 : (spoiled ? 2 : 3);
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_pulse at %0t: got kind %0d, expected none", $time, kind);
                end else begin
                    mon_p = exp_q.pop_front();
                    check("pulse_kind", 32'(kind), 32'(mon_p.kind));
                    if (mon_p.kind == 1) begin
                        check("ack_led", 32'(cand_led), 32'(mon_p.led));
                        check("ack_total", 32'(total_count), 32'(mon_p.total));
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] rv;
        int         r;

        // Reset state
        step(1, 0, 0, 4'b0000, 2'd0);
        idle(1);

        // Basic vote, plus extra presses during HOLD and after it
        step(0, 1, 0, 4'b0000, 2'd0);
        idle(1);
        step(0, 0, 0, 4'b0010, 2'd0);
        step(0, 0, 0, 4'b0001, 2'd0);
        idle(4);
        step(0, 0, 0, 4'b0001, 2'd0);
        idle(1);
        readback(2'd1);
        readback(2'd0);

        // Spoiled ballot
        step(0, 1, 0, 4'b0000, 2'd0);
        step(0, 0, 0, 4'b0101, 2'd0);
        idle(5);
        for (int i = 0; i < N_CAND; i++) readback(2'(i));

        // Timeout, then a late press
        step(0, 1, 0, 4'b0000, 2'd0);
        idle(10);
        step(0, 0, 0, 4'b1000, 2'd0);
        readback(2'd3);

        // Mode switch while armed
        step(0, 1, 0, 4'b0000, 2'd0);
        idle(2);
        step(0, 0, 1, 4'b0000, 2'd1);
        idle(TOUT + 2);

        // Vote on the expiry edge is accepted
        step(0, 1, 0, 4'b0000, 2'd0);
        idle(TOUT - 1);
        step(0, 0, 0, 4'b0100, 2'd0);
        idle(HOLD + 1);
        readback(2'd2);

        // Reset during HOLD
        step(0, 1, 0, 4'b0000, 2'd0);
        step(0, 0, 0, 4'b0100, 2'd0);
        idle(1);
        step(1, 0, 0, 4'b0000, 2'd0);
        idle(1);
        readback(2'd2);

        // Saturation on candidate 3
        for (int n = 0; n < 260; n++) begin
            step(0, 1, 0, 4'b0000, 2'd0);
            step(0, 0, 0, 4'b1000, 2'd0);
            idle(HOLD);
        end
        readback(2'd3);
        readback(2'd0);

        // Random traffic
        step(1, 0, 0, 4'b0000, 2'd0);
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)      rv = 4'b0000;
            else if (r < 9) rv = 4'b0001 << $urandom_range(0, 3);
            else            rv = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 11) == 0),
                 rv, 2'($urandom_range(0, 3)));
        end
        idle(HOLD + TOUT + 2);
        for (int i = 0; i < N_CAND; i++) readback(2'(i));

        check("pulse_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/vote_session_controller.md
Name: vote_session_controller

Overview:
- Sequences one voting session per voter and tallies votes for N_CAND candidates.
- Sits downstream of the per-candidate button_control instances and consumes their one-cycle valid_vote pulses.
- The presiding officer arms the machine for exactly one ballot; exactly one vote is accepted per arming. In result mode it exposes the per-candidate and total tallies.

Parameters:
N_CAND, 4, number of candidates (number of valid_vote inputs)
SEL_W, 2, width of result_sel; must satisfy 2**SEL_W >= N_CAND
CNT_W, 8, width of each tally and of the total counter
HOLD_CYCLES, 100, post-ballot lockout length in clock cycles (>=1)
ARM_TIMEOUT, 1000, cycles an armed ballot waits before auto-cancel (>=1)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
valid_vote  input  N_CAND  one-cycle pulses from the button_control instances, bit i = candidate i
enable_voter  input  1  officer pulse; arms one ballot
mode  input  1  0 = voting, 1 = result display
result_sel  input  SEL_W  candidate index shown on result_count
ready  output  1  high while the ballot is armed (ARMED state)
vote_ack  output  1  one-cycle pulse when a vote is counted
spoiled  output  1  one-cycle pulse when a multi-press ballot is rejected
timeout  output  1  one-cycle pulse when an armed ballot expires
cand_led  output  N_CAND  one-hot copy of the accepted candidate, held through HOLD
result_count  output  CNT_W  tally of candidate result_sel (mode=1), else 0
total_count  output  CNT_W  total accepted votes

Behaviour:
- Reset: state LOCKED, all tallies and total_count 0; ready, vote_ack, spoiled, timeout, cand_led and result_count all 0. Reset applied mid-ballot or mid-HOLD aborts the ballot immediately.
- All outputs are registered.
- States: LOCKED, ARMED, HOLD.
- LOCKED:
  - enable_voter=1 with mode=0 -> ARMED and the timeout counter loads 0.
  - enable_voter is ignored when mode=1.
- ARMED:
  - ready=1.
  - Evaluation priority each edge: mode=1 first, then valid_vote, then timeout.
  - mode=1 -> LOCKED. No pulse.
  - Exactly one valid_vote bit set:
    - tally[i] increments and total_count increments, each saturating at 2**CNT_W-1.
    - vote_ack=1 and cand_led=onehot(i) in the next cycle; the counts are visible in that same cycle.
    - Next state HOLD.
  - Two or more bits set in the same cycle: no increments; spoiled=1 next cycle; cand_led stays 0; next state HOLD.
  - Timeout counter reaches ARM_TIMEOUT-1 with no vote: timeout=1 next cycle; next state LOCKED.
  - A vote in the same cycle as timeout expiry is accepted (vote wins).
  - enable_voter while ARMED is ignored and does not restart the timeout.
- HOLD:
  - Lasts exactly HOLD_CYCLES cycles, then LOCKED. cand_led is held for the full duration.
  - All valid_vote and enable_voter activity is ignored.
  - cand_led clears on entry to LOCKED.
- vote_ack, spoiled and timeout are mutually exclusive single-cycle pulses.
- Result path:
  - result_count <= (mode=1 and result_sel < N_CAND) ? tally[result_sel] : 0, with one-cycle latency.
  - total_count is always driven, independent of mode.
- Tallies are never cleared except by reset.

Decomposition:
- voting_pkg holds:
  - the state enum (LOCKED/ARMED/HOLD);
  - a onehot_count/is_single_hot function;
  - default constants for N_CAND, CNT_W, HOLD_CYCLES and ARM_TIMEOUT.
- One sub-module, vote_tally:
  - bank of N_CAND saturating CNT_W counters plus the total counter;
  - inputs: increment strobe and candidate index; output: the registered, muxed read port.
  - The FSM and timers stay in vote_session_controller.

Test Plan:
(All use N_CAND=4, CNT_W=8, HOLD_CYCLES=4, ARM_TIMEOUT=8.)
- Basic vote: enable_voter pulse, then valid_vote=0010 two cycles later.
  - Required: vote_ack=1 for one cycle; cand_led=0010 for 4 cycles; tally[1]=1; total_count=1.
  - Then mode=1, result_sel=1 -> result_count=1 one cycle later.
- One vote per arming: after the accepted vote, a second pulse valid_vote=0001 during HOLD and another after return to LOCKED.
  - Required: tally[0]=0, total_count stays 1, no vote_ack.
- Spoiled ballot: armed, valid_vote=0101.
  - Required: spoiled pulse, all tallies 0, HOLD for 4 cycles, then ready=0.
- Timeout: armed with no vote for 8 cycles.
  - Required: timeout pulse; ready drops; a later valid_vote=1000 is not counted.
- Saturation: 260 armed votes for candidate 3.
  - Required: tally[3]=255 and total_count=255; vote_ack still pulses on every vote.
- Mode and reset interaction:
  - Mode switch to 1 while ARMED -> LOCKED with no pulses.
  - Reset during HOLD -> all outputs 0 and tallies 0 on the next cycle.
